// File: rtl/axi_frame_hdr.sv
// axi_frame_hdr: drains a sample stream and re-emits it as frames, each one
// led by a header word {seq_num, payload length}. An input tlast closes the
// current frame early. All outputs are registered (one-cycle latency), and
// payload keeps full throughput while the downstream is ready.
// DATA_WIDTH must be at least 2*CNT_WIDTH so that the header fields fit.
`timescale 1ns/1ps

module axi_frame_hdr #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic [CNT_WIDTH-1:0]  frame_len,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  seq_num,
  output logic                  short_frame
);

  typedef enum logic {ST_HDR, ST_PAY} state_t;

  state_t                state_q, state_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [CNT_WIDTH-1:0]  seq_q, seq_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  len_lat_q, len_lat_d;
  logic                  short_q, short_d;

  logic                  out_free;
  logic                  in_hs;
  logic [CNT_WIDTH-1:0]  len_eff;
  logic [CNT_WIDTH-1:0]  len_m1;
  logic                  beat_last;
  logic                  short_end;
  logic [DATA_WIDTH-1:0] hdr_word;

  // The output register can take a new word when empty or being drained.
  assign out_free      = ~m_tvalid_q | m_axis_tready;
  // Input is only accepted during payload, and only if the output can move.
  assign s_axis_tready = (state_q == ST_PAY) & out_free;
  assign in_hs         = s_axis_tvalid & s_axis_tready;

  // A zero length request still carries one payload beat.
  assign len_eff   = (frame_len == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : frame_len;
  assign len_m1    = len_lat_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  assign beat_last = (beat_cnt_q == len_m1) | s_axis_tlast;
  // A tlast on exactly the final counted beat is a normal end, not a short one.
  assign short_end = s_axis_tlast & (beat_cnt_q < len_m1);

  // Header layout: zero padding, then sequence number, then length in the LSBs.
  always_comb begin
    hdr_word = '0;
    hdr_word[2*CNT_WIDTH-1:0] = {seq_q, len_eff};
  end

  // Next-state and output-register update for the HDR/PAY framer.
  always_comb begin
    state_d    = state_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    seq_d      = seq_q;
    beat_cnt_d = beat_cnt_q;
    len_lat_d  = len_lat_q;
    short_d    = 1'b0;

    // A consumed (or empty) output slot goes invalid unless refilled below.
    if (out_free) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_HDR: begin
        // Only emit a header once there is payload waiting behind it.
        if (s_axis_tvalid && out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = hdr_word;
          m_tlast_d  = 1'b0;
          len_lat_d  = len_eff;
          beat_cnt_d = '0;
          state_d    = ST_PAY;
        end
      end
      ST_PAY: begin
        if (in_hs) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_axis_tdata;
          m_tlast_d  = beat_last;
          beat_cnt_d = beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          if (beat_last) begin
            seq_d   = seq_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            short_d = short_end;
            state_d = ST_HDR;
          end
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q    <= ST_HDR;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      seq_q      <= '0;
      beat_cnt_q <= '0;
      len_lat_q  <= '0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      seq_q      <= seq_d;
      beat_cnt_q <= beat_cnt_d;
      len_lat_q  <= len_lat_d;
      short_q    <= short_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign seq_num       = seq_q;
  assign short_frame   = short_q;

endmodule

// File: tb/tb_axi_frame_hdr.sv
// Directed testbench for axi_frame_hdr: a 32/16 instance for framing,
// backpressure, early tlast, length change and reset, plus a 8/4 instance
// for zero-length frames, sequence wrap and maximum frame length.
`timescale 1ns/1ps

module tb_axi_frame_hdr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (DATA_WIDTH=32, CNT_WIDTH=16)
  logic [15:0] frame_len;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
  logic [15:0] seq_num;
  logic        short_frame;

  // Narrow instance (DATA_WIDTH=8, CNT_WIDTH=4)
  logic [3:0]  f4_len;
  logic        s4_tvalid, s4_tlast, s4_tready;
  logic [7:0]  s4_tdata;
  logic        m4_tvalid, m4_tlast, m4_tready;
  logic [7:0]  m4_tdata;
  logic [3:0]  seq4;
  logic        short4;

  axi_frame_hdr #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .sync_reset(rst), .frame_len(frame_len),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .seq_num(seq_num), .short_frame(short_frame)
  );

  axi_frame_hdr #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .sync_reset(rst), .frame_len(f4_len),
    .s_axis_tvalid(s4_tvalid), .s_axis_tdata(s4_tdata), .s_axis_tlast(s4_tlast),
    .s_axis_tready(s4_tready),
    .m_axis_tvalid(m4_tvalid), .m_axis_tdata(m4_tdata), .m_axis_tlast(m4_tlast),
    .m_axis_tready(m4_tready),
    .seq_num(seq4), .short_frame(short4)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          c;
  } beat_t;

  beat_t q[$];
  beat_t q4[$];
  int short_cnt = 0;
  int short4_cnt = 0;
  int stall_viol = 0;
  int accept_viol = 0;
  logic [31:0] held_d;
  logic        held_l;
  bit          held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: samples at the falling edge, records transfers that
  // complete at the next rising edge, and watches stalled words.
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held && (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tlast !== held_l))
        stall_viol++;
      if (m_tvalid && !m_tready) begin
        held   = 1;
        held_d = m_tdata;
        held_l = m_tlast;
        if (s_tready) accept_viol++;
      end else begin
        held = 0;
      end
      if (m_tvalid && m_tready) q.push_back('{m_tdata, m_tlast, cyc});
      if (short_frame) short_cnt++;
      if (short4) short4_cnt++;
      if (m4_tvalid && m4_tready) q4.push_back('{{24'd0, m4_tdata}, m4_tlast, cyc});
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge clk);
    while (!s_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout data=%0h not accepted within 300 cycles", d);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send4(input logic [7:0] d, input logic l);
    int n = 0;
    s4_tvalid = 1'b1;
    s4_tdata  = d;
    s4_tlast  = l;
    @(negedge clk);
    while (!s4_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s4_tready) begin
      checks++;
      failures++;
      $display("FAIL send4_timeout data=%0h not accepted within 300 cycles", d);
    end
    @(posedge clk);
    #1;
    s4_tvalid = 1'b0;
    s4_tlast  = 1'b0;
  endtask

  task automatic wait_q(input int n_items);
    int n = 0;
    while (q.size() < n_items && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame_len = 16'd4; s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 1'b1;
    f4_len = 4'd0; s4_tvalid = 0; s4_tdata = 0; s4_tlast = 0; m4_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%0h exp=0", m_tdata); end
    checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
    checks++; if (seq_num !== 16'd0) begin failures++; $display("FAIL reset_seq got=%0d exp=0", seq_num); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_tready); end
    checks++; if (short_frame !== 1'b0) begin failures++; $display("FAIL reset_short got=%b exp=0", short_frame); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL idle_no_header got=%b exp=0", m_tvalid); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL idle_tready got=%b exp=0", s_tready); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_basic();
    logic [31:0] ed[$];
    logic        el[$];
    ed = {32'h0000_0004, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0001_0004, 32'd5, 32'd6, 32'd7, 32'd8};
    el = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    q.delete();
    frame_len = 16'd4;
    m_tready  = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
    wait_q(10);
    checks++; if (q.size() != 10) begin failures++; $display("FAIL basic_count got=%0d exp=10", q.size()); end
    for (int i = 0; i < 10 && i < q.size(); i++) begin
      checks++; if (q[i].d !== ed[i]) begin failures++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, q[i].d, ed[i]); end
      checks++; if (q[i].l !== el[i]) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, q[i].l, el[i]); end
    end
    if (q.size() == 10) begin
      checks++; if (q[9].c - q[0].c != 9) begin failures++; $display("FAIL basic_span got=%0d exp=9", q[9].c - q[0].c); end
    end
    checks++; if (seq_num !== 16'd2) begin failures++; $display("FAIL basic_seq got=%0d exp=2", seq_num); end
    $display("test_basic done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    logic [31:0] ed[$];
    logic        el[$];
    ed = {32'h0002_0004, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0003_0004, 32'd5, 32'd6, 32'd7, 32'd8};
    el = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    q.delete();
    stall_viol  = 0;
    accept_viol = 0;
    frame_len   = 16'd4;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          repeat ($urandom_range(0, 2)) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(32'(i), 1'b0);
        end
      end
      begin
        int n = 0;
        while (q.size() < 10 && n < 400) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
          n++;
        end
      end
    join
    m_tready = 1'b1;
    wait_q(10);
    checks++; if (q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", q.size()); end
    for (int i = 0; i < 10 && i < q.size(); i++) begin
      checks++; if (q[i].d !== ed[i]) begin failures++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, q[i].d, ed[i]); end
      checks++; if (q[i].l !== el[i]) begin failures++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, q[i].l, el[i]); end
    end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
    checks++; if (accept_viol != 0) begin failures++; $display("FAIL bp_no_accept_held got=%0d exp=0", accept_viol); end
    checks++; if (seq_num !== 16'd4) begin failures++; $display("FAIL bp_seq got=%0d exp=4", seq_num); end
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_early_tlast();
    logic [31:0] ed[$];
    logic        el[$];
    int          sc0;
    ed = {32'h0004_0008, 32'd1, 32'd2, 32'd3, 32'h0005_0001, 32'h0000_000A,
          32'h0006_0002, 32'h0000_000B, 32'h0000_000C};
    el = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    q.delete();
    sc0 = short_cnt;
    frame_len = 16'd8;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (short_cnt - sc0 != 1) begin failures++; $display("FAIL early_short_pulse got=%0d exp=1", short_cnt - sc0); end
    // tlast on beat 1 with length 1, then tlast on exactly the 2nd of 2 beats.
    @(posedge clk); #1;
    frame_len = 16'd1;
    send(32'h0A, 1'b1);
    frame_len = 16'd2;
    send(32'h0B, 1'b0);
    send(32'h0C, 1'b1);
    wait_q(9);
    checks++; if (q.size() != 9) begin failures++; $display("FAIL early_count got=%0d exp=9", q.size()); end
    for (int i = 0; i < 9 && i < q.size(); i++) begin
      checks++; if (q[i].d !== ed[i]) begin failures++; $display("FAIL early_data[%0d] got=%0h exp=%0h", i, q[i].d, ed[i]); end
      checks++; if (q[i].l !== el[i]) begin failures++; $display("FAIL early_last[%0d] got=%b exp=%b", i, q[i].l, el[i]); end
    end
    checks++; if (short_cnt - sc0 != 1) begin failures++; $display("FAIL early_no_extra_pulse got=%0d exp=1", short_cnt - sc0); end
    checks++; if (seq_num !== 16'd7) begin failures++; $display("FAIL early_seq got=%0d exp=7", seq_num); end
    $display("test_early_tlast done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_len_change();
    logic [31:0] ed[$];
    logic        el[$];
    ed = {32'h0007_0004, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0008_0002, 32'd5, 32'd6};
    el = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    q.delete();
    frame_len = 16'd4;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    frame_len = 16'd2;
    for (int i = 3; i <= 6; i++) send(32'(i), 1'b0);
    wait_q(8);
    checks++; if (q.size() != 8) begin failures++; $display("FAIL lenchg_count got=%0d exp=8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      checks++; if (q[i].d !== ed[i]) begin failures++; $display("FAIL lenchg_data[%0d] got=%0h exp=%0h", i, q[i].d, ed[i]); end
      checks++; if (q[i].l !== el[i]) begin failures++; $display("FAIL lenchg_last[%0d] got=%b exp=%b", i, q[i].l, el[i]); end
    end
    checks++; if (seq_num !== 16'd9) begin failures++; $display("FAIL lenchg_seq got=%0d exp=9", seq_num); end
    $display("test_len_change done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed[$];
    logic        el[$];
    ed = {32'h0000_0004, 32'd16, 32'd17, 32'd18, 32'd19};
    el = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    frame_len = 16'd4;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    // Beat 2 now sits in the output register; assert reset between edges.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (seq_num !== 16'd0) begin failures++; $display("FAIL rstmid_seq got=%0d exp=0", seq_num); end
    checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL rstmid_tlast got=%b exp=0", m_tlast); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    for (int i = 16; i <= 19; i++) send(32'(i), 1'b0);
    wait_q(5);
    checks++; if (q.size() != 5) begin failures++; $display("FAIL rstmid_count got=%0d exp=5", q.size()); end
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      checks++; if (q[i].d !== ed[i]) begin failures++; $display("FAIL rstmid_data[%0d] got=%0h exp=%0h", i, q[i].d, ed[i]); end
      checks++; if (q[i].l !== el[i]) begin failures++; $display("FAIL rstmid_last[%0d] got=%b exp=%b", i, q[i].l, el[i]); end
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_wrap();
    int n = 0;
    q4.delete();
    short4_cnt = 0;
    f4_len    = 4'd0;
    m4_tready = 1'b1;
    // 17 frames of length 0 (treated as 1): seq runs 0..15 then wraps to 0.
    for (int k = 0; k < 17; k++) send4(8'(k + 1), 1'b0);
    while (q4.size() < 34 && n < 400) begin @(negedge clk); n++; end
    checks++; if (q4.size() != 34) begin failures++; $display("FAIL wrap_count got=%0d exp=34", q4.size()); end
    for (int k = 0; k < 17 && 2*k+1 < q4.size(); k++) begin
      checks++; if (q4[2*k].d !== 32'((k % 16) * 16 + 1)) begin failures++; $display("FAIL wrap_hdr[%0d] got=%0h exp=%0h", k, q4[2*k].d, (k % 16) * 16 + 1); end
      checks++; if (q4[2*k].l !== 1'b0) begin failures++; $display("FAIL wrap_hdr_last[%0d] got=%b exp=0", k, q4[2*k].l); end
      checks++; if (q4[2*k+1].d !== 32'(k + 1)) begin failures++; $display("FAIL wrap_pay[%0d] got=%0h exp=%0h", k, q4[2*k+1].d, k + 1); end
      checks++; if (q4[2*k+1].l !== 1'b1) begin failures++; $display("FAIL wrap_pay_last[%0d] got=%b exp=1", k, q4[2*k+1].l); end
    end
    if (q4.size() == 34) begin
      checks++; if (q4[33].c - q4[0].c != 33) begin failures++; $display("FAIL wrap_span got=%0d exp=33", q4[33].c - q4[0].c); end
    end
    checks++; if (seq4 !== 4'd1) begin failures++; $display("FAIL wrap_seq got=%0d exp=1", seq4); end
    // Maximum length frame (15 beats), tlast on exactly the final beat.
    q4.delete();
    f4_len = 4'd15;
    for (int i = 1; i <= 15; i++) send4(8'(i), (i == 15) ? 1'b1 : 1'b0);
    n = 0;
    while (q4.size() < 16 && n < 400) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++; if (q4.size() != 16) begin failures++; $display("FAIL maxlen_count got=%0d exp=16", q4.size()); end
    if (q4.size() == 16) begin
      checks++; if (q4[0].d !== 32'h1F) begin failures++; $display("FAIL maxlen_hdr got=%0h exp=1f", q4[0].d); end
      checks++; if (q4[14].l !== 1'b0) begin failures++; $display("FAIL maxlen_last14 got=%b exp=0", q4[14].l); end
      checks++; if (q4[15].l !== 1'b1 || q4[15].d !== 32'd15) begin failures++; $display("FAIL maxlen_final got=%0h/%b exp=f/1", q4[15].d, q4[15].l); end
    end
    checks++; if (short4_cnt != 0) begin failures++; $display("FAIL maxlen_short got=%0d exp=0", short4_cnt); end
    checks++; if (seq4 !== 4'd2) begin failures++; $display("FAIL maxlen_seq got=%0d exp=2", seq4); end
    $display("test_wrap done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_tlast();
    test_len_change();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_frame_hdr.md
# axi_frame_hdr

Stream framer for the channelizer output path, directly downstream of the AXI FIFO. It drains FIFO samples and emits fixed-length frames, each preceded by one header word carrying a sequence number and the requested payload length. An early input `tlast` (a channel-block boundary) closes the current frame short. Output is fully registered with one-cycle latency, and full throughput is kept within a frame.

## Interface
- `DATA_WIDTH`, 32, sample/header word width; must be >= 2*`CNT_WIDTH`.
- `CNT_WIDTH`, 16, width of the sequence counter, beat counter and length field.
- `clk`  in  1  clock; all logic rising-edge.
- `sync_reset`  in  1  reset; asynchronous assert, active-high, released synchronously to `clk` by the system.
- `frame_len`  in  `CNT_WIDTH`  payload beats per frame; sampled when a header is loaded; 0 treated as 1.
- `s_axis_tvalid`  in  1  input sample valid (from FIFO `m_axis_tvalid`).
- `s_axis_tdata`  in  `DATA_WIDTH`  input sample.
- `s_axis_tlast`  in  1  end of channel block; forces end of frame.
- `s_axis_tready`  out  1  input accept.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tdata`  out  `DATA_WIDTH`  header or payload word.
- `m_axis_tlast`  out  1  last payload beat of frame.
- `m_axis_tready`  in  1  downstream accept.
- `seq_num`  out  `CNT_WIDTH`  sequence number of the next header to be emitted.
- `short_frame`  out  1  one-cycle pulse when a frame is closed by `s_axis_tlast` before `frame_len` beats.

## Operation
- **Output register.** `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` are registers. `out_free = ~m_axis_tvalid | m_axis_tready`.
- **FSM states:** HDR, PAY.
- **HDR:**
  - `s_axis_tready = 0`.
  - When `s_axis_tvalid` and `out_free`:
    - Load the header: `m_axis_tdata = {zeros, seq_num, len_eff}`, where `len_eff = (frame_len==0) ? 1 : frame_len`. `seq_num` occupies bits [2*CNT_WIDTH-1:CNT_WIDTH]; `len_eff` occupies [CNT_WIDTH-1:0].
    - Set `m_axis_tlast = 0`, latch `len_eff`, clear `beat_cnt`, go to PAY.
  - No header is emitted while the input is empty.
- **PAY:**
  - `s_axis_tready = out_free`; this is a combinational path from `m_axis_tready`.
  - On an input handshake: load `s_axis_tdata` and increment `beat_cnt`.
  - The beat is last if `beat_cnt == len_lat-1` or `s_axis_tlast`. A last beat sets `m_axis_tlast = 1`, increments `seq_num` (modulo 2^`CNT_WIDTH`, wraps to 0) and returns to HDR.
  - `short_frame` pulses for one cycle, with the handshake, when `s_axis_tlast` ends the frame and `beat_cnt < len_lat-1`.
  - `s_axis_tlast` on exactly the `len_lat`-th beat is a normal end: no pulse.
- **Output hold.** When the output does not advance (`m_axis_tvalid=1`, `m_axis_tready=0`), the output holds all fields stable.
- **`frame_len` timing.** Changes to `frame_len` mid-frame do not affect the current frame.
- **Reset:** state=HDR, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `seq_num`=0, `beat_cnt`=0, `short_frame`=0, and hence `s_axis_tready`=0.
  - Reset mid-frame discards the partial frame with no trailing `tlast`.
  - Output valid drops immediately on assertion.

## Timing
- **Latency:** an input handshake at edge N makes the word visible on `m_axis_*` after edge N (1 cycle). A header loads 1 cycle after `s_axis_tvalid` is seen in HDR with `out_free`.
- **Throughput:** frame of L payload beats occupies L+1 output beats. Payload runs back-to-back with `m_axis_tready` held high.
- **Frame wrap-around:** the next header follows the last beat of a frame with no bubble when the input is valid.
- **Simultaneous events:**
  - Downstream ready and new input in the same cycle → replace the register contents.
  - `s_axis_tlast` on beat 1 with `len_lat=1` → normal end, no pulse.
- **Counter widths:** `beat_cnt` and `seq_num` are `CNT_WIDTH` bits. `frame_len` = 2^`CNT_WIDTH`-1 must work.

## Test plan
- **Basic framing.** `frame_len`=4, continuous input 1..8, ready=1 → output H(seq0,len4),1,2,3,4(last),H(seq1,len4),5,6,7,8(last). 10 beats in 10 consecutive cycles after the first.
- **Backpressure.** Same stimulus with `m_axis_tready` toggling 1010… plus random input-valid gaps → identical output sequence. Data is stable while stalled. No input is accepted when the output is held.
- **Early tlast.** `frame_len`=8, `s_axis_tlast` on input beat 3 → H(len8),d1,d2,d3(last), one `short_frame` pulse. Next header has seq incremented.
- **Length zero and seq wrap.** `CNT_WIDTH`=4, `frame_len`=0 → every frame is H + 1 beat(last). After 16 frames `seq_num` wraps 15→0.
- **Reset mid-frame.** Assert `sync_reset` asynchronously after payload beat 2 of 4 → `m_axis_tvalid`=0 before the next edge and `seq_num`=0. The first post-reset output is H(seq0) followed by fresh data.
- **Late frame_len change.** Change `frame_len` 4→2 mid-frame → the current frame completes with 4 beats; the next header shows len2.
